// File: rtl/lsu_mem_stage.sv
//------------------------------------------------------------------------------
// lsu_mem_stage : load/store unit with a single-outstanding req/ack memory bus
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lsu_mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [2:0]       op_q;
    logic [1:0]       lane_q;
    logic [CNT_W-1:0] cnt;

    logic        is_store;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign in_ready = (state == IDLE);

    // Decode of the incoming request; only meaningful while in IDLE.
    always_comb begin
        is_store   = op[2] & (op[1] | op[0]);
        is_half    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        is_word    = (op == 3'b010) || (op == 3'b111);
        misaligned = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
        if (is_word) begin
            be_new    = 4'b1111;
            wdata_new = wdata;
        end else if (is_half) begin
            be_new    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{wdata[15:0]}};
        end else begin
            be_new    = 4'b0001 << addr[1:0];
            wdata_new = {4{wdata[7:0]}};
        end
    end

    // Lane selection and extension of returning load data.
    always_comb begin
        case (lane_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_data = mem_rdata;
            3'b011:  ld_data = {24'd0, ld_byte};
            3'b100:  ld_data = {16'd0, ld_half};
            default: ld_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= 3'd0;
            lane_q    <= 2'd0;
            cnt       <= '0;
            out_valid <= 1'b0;
            rdata     <= 32'd0;
            err       <= 1'b0;
            err_code  <= 2'b00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q   <= op;
                        lane_q <= addr[1:0];
                        if (misaligned) begin
                            state     <= RESP;
                            out_valid <= 1'b1;
                            rdata     <= 32'd0;
                            err       <= 1'b1;
                            err_code  <= 2'b01;
                        end else begin
                            state     <= BUS;
                            cnt       <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= be_new;
                            mem_wdata <= wdata_new;
                        end
                    end
                end
                BUS: begin
                    // An ack on the final counted cycle still completes normally.
                    if (mem_ack) begin
                        state     <= RESP;
                        mem_req   <= 1'b0;
                        out_valid <= 1'b1;
                        rdata     <= ld_data;
                        err       <= 1'b0;
                        err_code  <= 2'b00;
                    end else if (cnt == CNT_LAST) begin
                        state     <= RESP;
                        mem_req   <= 1'b0;
                        out_valid <= 1'b1;
                        rdata     <= 32'd0;
                        err       <= 1'b1;
                        err_code  <= 2'b10;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
//------------------------------------------------------------------------------
// tb_lsu_mem_stage : vector table, hand sequences and randomized model checks
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_lsu_mem_stage;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  err_code;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    lsu_mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .addr(addr), .wdata(wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .rdata(rdata), .err(err), .err_code(err_code),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  code;
        int          bus;
        int          lat;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          ack_at;
        int          hold;
        exp_t        e;
    } vec_t;

    typedef struct {
        logic        idle;
        logic        req;
        logic        we;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] mwdata;
        int          bus;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  code;
        logic        stable_bad;
        logic        hold_bad;
        logic        released;
    } obs_t;

    task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %h want %h", tag, nm, act, exp);
        end
    endtask

    // Expected behaviour from access size/offset arithmetic.
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] rd, input int ack_at);
        exp_t   e;
        int     size;
        int     off;
        bit     st;
        longint v;
        e = '{req: 0, we: 0, be: 0, mwdata: 0, rdata: 0, err: 0, code: 0, bus: 0, lat: 0};
        size = (o == 0 || o == 3 || o == 5) ? 1 : (o == 1 || o == 4 || o == 6) ? 2 : 4;
        off  = int'(a[1:0]);
        st   = (o >= 5);
        if (off % size != 0) begin
            e.err = 1; e.code = 2'b01; e.lat = 1;
            return e;
        end
        e.req = 1;
        e.we  = st;
        e.be  = 4'(((1 << size) - 1) << off);
        e.mwdata = (size == 1) ? 32'(wd[7:0]) * 32'h01010101 :
                   (size == 2) ? 32'(wd[15:0]) * 32'h00010001 : wd;
        if (ack_at < 1 || ack_at > TIMEOUT) begin
            e.err = 1; e.code = 2'b10; e.bus = TIMEOUT; e.lat = TIMEOUT + 1;
            return e;
        end
        e.bus = ack_at;
        e.lat = ack_at + 1;
        if (!st) begin
            v = ({32'd0, rd} >> (8 * off)) & ((64'd1 << (8 * size)) - 1);
            if ((o == 0 || o == 1) && v >= longint'(64'd1 << (8 * size - 1)))
                v = v - longint'(64'd1 << (8 * size));
            e.rdata = v[31:0];
        end
        return e;
    endfunction

    task automatic run_access(input logic [2:0] o_op, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int ack_at, input int hold, output obs_t r);
        r = '{idle: 0, req: 0, we: 0, maddr: 0, be: 0, mwdata: 0, bus: 0, lat: 0,
              rdata: 0, err: 0, code: 0, stable_bad: 0, hold_bad: 0, released: 0};
        r.idle   = in_ready;
        in_valid = 1'b1; op = o_op; addr = a; wdata = wd;
        @(negedge clk);
        in_valid = 1'b0; op = 3'($urandom); addr = $urandom; wdata = $urandom;
        for (int t = 1; t <= 60; t++) begin
            if (mem_req) begin
                r.bus++;
                if (!r.req) begin
                    r.req = 1; r.we = mem_we; r.maddr = mem_addr; r.be = mem_be; r.mwdata = mem_wdata;
                end else if ({mem_we, mem_addr, mem_be, mem_wdata} !== {r.we, r.maddr, r.be, r.mwdata}) begin
                    r.stable_bad = 1;
                end
            end
            if (out_valid) begin
                r.lat = t;
                break;
            end
            mem_ack   = mem_req && (t == ack_at);
            mem_rdata = mem_ack ? rd : $urandom;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        if (r.lat != 0) begin
            r.rdata = rdata; r.err = err; r.code = err_code;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (!out_valid || rdata !== r.rdata || err !== r.err || err_code !== r.code || in_ready)
                    r.hold_bad = 1;
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            r.released = !out_valid && in_ready;
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] a, input obs_t r, input exp_t e);
        chk(tag, "idle",  32'(r.idle), 32'd1);
        chk(tag, "req",   32'(r.req), 32'(e.req));
        chk(tag, "lat",   r.lat, e.lat);
        chk(tag, "bus",   r.bus, e.bus);
        chk(tag, "rdata", r.rdata, e.rdata);
        chk(tag, "err",   32'(r.err), 32'(e.err));
        chk(tag, "code",  32'(r.code), 32'(e.code));
        if (e.req) begin
            chk(tag, "we",    32'(r.we), 32'(e.we));
            chk(tag, "maddr", r.maddr, {a[31:2], 2'b00});
            chk(tag, "be",    32'(r.be), 32'(e.be));
            if (e.we) chk(tag, "mwdata", r.mwdata, e.mwdata);
            chk(tag, "stable", 32'(r.stable_bad), 32'd0);
        end
        chk(tag, "hold",    32'(r.hold_bad), 32'd0);
        chk(tag, "release", 32'(r.released), 32'd1);
    endtask

    function automatic vec_t mk(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input int ack_at, input int hold,
                                input logic req, input logic we, input logic [3:0] be,
                                input logic [31:0] mwd, input logic [31:0] rdv,
                                input logic er, input logic [1:0] code, input int bus, input int lat);
        vec_t v;
        v.op = o; v.addr = a; v.wdata = wd; v.rd = rd; v.ack_at = ack_at; v.hold = hold;
        v.e = '{req: req, we: we, be: be, mwdata: mwd, rdata: rdv, err: er, code: code, bus: bus, lat: lat};
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        obs_t r;
        exp_t e;
        logic [2:0]  ro;
        logic [31:0] ra, rw, rr;
        int          rack;
        int          bad;

        vecs.push_back(mk(3'd2, 32'h1000, 32'h0,        32'hDEADBEEF, 1,  0, 1, 0, 4'hF, 0,            32'hDEADBEEF, 0, 2'b00, 1,  2));
        vecs.push_back(mk(3'd0, 32'h1003, 32'h0,        32'h80FF7F01, 2,  0, 1, 0, 4'h8, 0,            32'hFFFFFF80, 0, 2'b00, 2,  3));
        vecs.push_back(mk(3'd3, 32'h1003, 32'h0,        32'h80FF7F01, 1,  0, 1, 0, 4'h8, 0,            32'h00000080, 0, 2'b00, 1,  2));
        vecs.push_back(mk(3'd6, 32'h2002, 32'h1234ABCD, 32'h55555555, 3,  0, 1, 1, 4'hC, 32'hABCDABCD, 32'h0,        0, 2'b00, 3,  4));
        vecs.push_back(mk(3'd2, 32'h3001, 32'h0,        32'h0,        1,  0, 0, 0, 4'h0, 0,            32'h0,        1, 2'b01, 0,  1));
        vecs.push_back(mk(3'd1, 32'h4000, 32'h0,        32'h0,        0,  0, 1, 0, 4'h3, 0,            32'h0,        1, 2'b10, 16, 17));
        vecs.push_back(mk(3'd1, 32'h4000, 32'h0,        32'h00008001, 16, 0, 1, 0, 4'h3, 0,            32'hFFFF8001, 0, 2'b00, 16, 17));
        vecs.push_back(mk(3'd4, 32'h4002, 32'h0,        32'h9ABC1234, 1,  5, 1, 0, 4'hC, 0,            32'h00009ABC, 0, 2'b00, 1,  2));
        vecs.push_back(mk(3'd5, 32'h5001, 32'h000000A5, 32'h0,        1,  0, 1, 1, 4'h2, 32'hA5A5A5A5, 32'h0,        0, 2'b00, 1,  2));
        vecs.push_back(mk(3'd7, 32'h6000, 32'h11223344, 32'h0,        2,  0, 1, 1, 4'hF, 32'h11223344, 32'h0,        0, 2'b00, 2,  3));
        vecs.push_back(mk(3'd6, 32'h2001, 32'hFFFF,     32'h0,        1,  5, 0, 0, 4'h0, 0,            32'h0,        1, 2'b01, 0,  1));
        vecs.push_back(mk(3'd1, 32'h4003, 32'h0,        32'h0,        1,  0, 0, 0, 4'h0, 0,            32'h0,        1, 2'b01, 0,  1));

        // Reset state, sampled while reset is held.
        @(negedge clk);
        chk("reset", "in_ready",  32'(in_ready), 32'd1);
        chk("reset", "out_valid", 32'(out_valid), 32'd0);
        chk("reset", "mem_req",   32'(mem_req), 32'd0);
        chk("reset", "outs",      {mem_be, mem_we, err, err_code}, 32'd0);
        chk("reset", "mem_addr",  mem_addr, 32'd0);
        chk("reset", "rdata",     rdata | mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_access(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].ack_at, vecs[i].hold, r);
            check_all($sformatf("vec%0d", i), vecs[i].addr, r, vecs[i].e);
        end

        // Reset while a bus request is outstanding, then a stray late ack.
        in_valid = 1'b1; op = 3'd2; addr = 32'h7000; wdata = 32'd0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_mid", "req_before", 32'(mem_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid", "req_async",   32'(mem_req), 32'd0);
        chk("rst_mid", "valid_async", 32'(out_valid), 32'd0);
        chk("rst_mid", "ready_async", 32'(in_ready), 32'd1);
        #1 rst_n = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_ack = 1'b0;
        bad = 0;
        repeat (3) begin
            if (out_valid || mem_req || !in_ready) bad = 1;
            @(negedge clk);
        end
        chk("rst_mid", "late_ack", bad, 0);

        // Randomized accesses against the model.
        for (int n = 0; n < 150; n++) begin
            ro = 3'($urandom);
            ra = $urandom;
            rw = $urandom;
            rr = $urandom;
            rack = ($urandom_range(0, 3) != 0) ? $urandom_range(1, 3) : $urandom_range(0, 18);
            e = model(ro, ra, rw, rr, rack);
            run_access(ro, ra, rw, rr, rack, $urandom_range(0, 2), r);
            check_all($sformatf("rnd%0d", n), ra, r, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
